// File: rtl/mem_pkg.sv
// Shared types and width helpers for the data-cache line memory backend.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  function automatic int line_words(int line_addr_len);
    return 1 << line_addr_len;
  endfunction

  function automatic int line_bits(int line_addr_len);
    return 32 << line_addr_len;
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Word-wide main memory: port A for line beats (comb read),
// port B for debug access (registered read, loses write conflicts).
module mem_word_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [31:0]   b_wdata,
  output logic [31:0]   b_rdata
);

  logic [31:0] mem [2**AW];

  assign a_rdata = mem[a_addr];

  // Port A is written last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
    if (a_we) mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) b_rdata <= '0;
    else      b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/line_mem_backend.sv
// Line refill / write-back engine below the data cache, with
// programmable first-beat latency and a word-wide debug port.
module line_mem_backend
  import mem_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_ADDR_LEN  = 12,
  parameter int LATENCY       = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   mem_rd_req,
  input  logic                                   mem_wr_req,
  input  logic [MEM_ADDR_LEN-LINE_ADDR_LEN-1:0]  mem_addr,
  input  logic [line_bits(LINE_ADDR_LEN)-1:0]    mem_wr_line,
  output logic [line_bits(LINE_ADDR_LEN)-1:0]    mem_rd_line,
  output logic                                   mem_gnt,
  output logic                                   mem_busy,
  input  logic [31:0]                            debug_addr,
  input  logic                                   debug_we,
  input  logic [31:0]                            debug_wdata,
  output logic [31:0]                            debug_rdata,
  output logic [31:0]                            rd_count,
  output logic [31:0]                            wr_count
);

  localparam int IW = MEM_ADDR_LEN - LINE_ADDR_LEN;
  localparam int LB = line_bits(LINE_ADDR_LEN);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_t                 state;
  logic [CW-1:0]              lat_cnt;
  logic [LINE_ADDR_LEN-1:0]   beat;
  logic                       req_wr;
  logic [IW-1:0]              req_line;
  logic [LB-1:0]              req_data;

  logic [MEM_ADDR_LEN-1:0]    a_addr;
  logic                       a_we;
  logic [31:0]                a_wdata;
  logic [31:0]                a_rdata;
  logic                       unused_debug_bits;

  assign a_addr   = {req_line, beat};
  assign a_wdata  = req_data[{beat, 5'd0} +: 32];
  // A reset edge mid-write must not land the pending beat.
  assign a_we     = (state == XFER) && req_wr && rst;
  assign mem_gnt  = (state == DONE);
  assign mem_busy = (state != IDLE);

  assign unused_debug_bits = ^{debug_addr[31:MEM_ADDR_LEN+2],
                               debug_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      beat        <= '0;
      req_wr      <= 1'b0;
      req_line    <= '0;
      req_data    <= '0;
      mem_rd_line <= '0;
      rd_count    <= '0;
      wr_count    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_rd_req || mem_wr_req) begin
            req_wr   <= mem_wr_req;
            req_line <= mem_addr;
            req_data <= mem_wr_line;
            beat     <= '0;
            if (LATENCY == 0) begin
              state <= XFER;
            end else begin
              state   <= BUSY;
              lat_cnt <= CW'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (lat_cnt == '0) state <= XFER;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        XFER: begin
          if (!req_wr) mem_rd_line[{beat, 5'd0} +: 32] <= a_rdata;
          beat <= beat + 1'b1;
          if (beat == '1) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          if (req_wr) wr_count <= wr_count + 1'b1;
          else        rd_count <= rd_count + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_word_ram #(
    .AW (MEM_ADDR_LEN)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_addr  (a_addr),
    .a_we    (a_we),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .b_addr  (debug_addr[MEM_ADDR_LEN+1:2]),
    .b_we    (debug_we),
    .b_wdata (debug_wdata),
    .b_rdata (debug_rdata)
  );

endmodule

// File: tb/tb_line_mem_backend.sv
// Directed checks of line_mem_backend at LATENCY=4 and LATENCY=0.
module tb_line_mem_backend;

  logic         clk = 1'b0;
  logic         rst;

  logic         rd_req, wr_req, gnt, busy, dbg_we;
  logic [8:0]   addr;
  logic [255:0] wr_line, rd_line;
  logic [31:0]  dbg_addr, dbg_wdata, dbg_rdata, rd_cnt, wr_cnt;

  logic         b_rd_req, b_wr_req, b_gnt, b_busy, b_dbg_we;
  logic [8:0]   b_addr;
  logic [255:0] b_wr_line, b_rd_line;
  logic [31:0]  b_dbg_addr, b_dbg_wdata, b_dbg_rdata, b_rd_cnt, b_wr_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  line_mem_backend #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(12), .LATENCY(4)) u_dut (
    .clk(clk), .rst(rst),
    .mem_rd_req(rd_req), .mem_wr_req(wr_req), .mem_addr(addr),
    .mem_wr_line(wr_line), .mem_rd_line(rd_line),
    .mem_gnt(gnt), .mem_busy(busy),
    .debug_addr(dbg_addr), .debug_we(dbg_we), .debug_wdata(dbg_wdata),
    .debug_rdata(dbg_rdata), .rd_count(rd_cnt), .wr_count(wr_cnt)
  );

  line_mem_backend #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(12), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .mem_rd_req(b_rd_req), .mem_wr_req(b_wr_req), .mem_addr(b_addr),
    .mem_wr_line(b_wr_line), .mem_rd_line(b_rd_line),
    .mem_gnt(b_gnt), .mem_busy(b_busy),
    .debug_addr(b_dbg_addr), .debug_we(b_dbg_we), .debug_wdata(b_dbg_wdata),
    .debug_rdata(b_dbg_rdata), .rd_count(b_rd_cnt), .wr_count(b_wr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
    return l;
  endfunction

  task automatic dbg_rd(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    dbg_we   = 1'b0;
    dbg_addr = a;
    tick();
    check(tag, dbg_rdata, exp);
  endtask

  task automatic wait_gnt(input string tag, input int start,
                          input int exp_lat);
    int n;
    n = start;
    while (!gnt && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    wr_line = '0;
    tick();
    check({tag, "_gnt_w"}, {31'd0, gnt}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic [8:0] line, input logic [255:0] data,
                         input int exp_lat);
    rd_req  = rd;
    wr_req  = wr;
    addr    = line;
    wr_line = data;
    tick();
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_gnt(tag, 0, exp_lat);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int saw;
    int np;
    int gidx [3];

    rst = 1'b0;
    rd_req = 0; wr_req = 0; addr = '0; wr_line = '0;
    dbg_addr = '0; dbg_we = 0; dbg_wdata = '0;
    b_rd_req = 0; b_wr_req = 0; b_addr = '0; b_wr_line = '0;
    b_dbg_addr = '0; b_dbg_we = 0; b_dbg_wdata = '0;
    do_reset();

    check("rst_gnt", {31'd0, gnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdline", rd_line[31:0], 32'd0);
    check("rst_dbg", dbg_rdata, 32'd0);
    check("rst_rdcnt", rd_cnt, 32'd0);
    check("rst_wrcnt", wr_cnt, 32'd0);

    for (int i = 0; i < 16; i++) begin
      dbg_we    = 1'b1;
      dbg_addr  = i * 4;
      dbg_wdata = 32'h100 + i;
      tick();
    end
    dbg_we = 1'b0;

    run_txn("rd1", 1'b1, 1'b0, 9'd1, '0, 12);
    for (int k = 0; k < 8; k++)
      check($sformatf("rd1_w%0d", k), rd_line[k*32 +: 32], 32'h108 + k);
    check("rd1_cnt", rd_cnt, 32'd1);

    run_txn("wr2", 1'b0, 1'b1, 9'd2, mk_line(32'hA0), 12);
    dbg_rd("wr2_dbg0", 32'h40, 32'hA0);
    dbg_rd("wr2_dbg7", 32'h5C, 32'hA7);
    check("wr2_cnt", wr_cnt, 32'd1);
    check("wr2_rdline", rd_line[31:0], 32'h108);

    do_reset();
    run_txn("both3", 1'b1, 1'b1, 9'd3, mk_line(32'hB0), 12);
    check("both3_wr", wr_cnt, 32'd1);
    check("both3_rd", rd_cnt, 32'd0);
    check("both3_rdline", rd_line[31:0], 32'd0);
    dbg_rd("both3_dbg", 32'h60, 32'hB0);

    do_reset();
    wr_req  = 1'b1;
    addr    = 9'd0;
    wr_line = mk_line(32'hC0);
    for (int e = 0; e < 8; e++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wr_req = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    saw = 0;
    for (int e = 0; e < 15; e++) begin
      if (gnt) saw++;
      tick();
    end
    check("abort_gnt", saw, 0);
    check("abort_wr", wr_cnt, 32'd0);
    check("abort_rd", rd_cnt, 32'd0);
    for (int k = 0; k < 8; k++)
      dbg_rd($sformatf("abort_w%0d", k), k * 4,
             (k < 3) ? 32'hC0 + k : 32'h100 + k);

    wr_req  = 1'b1;
    addr    = 9'h1FF;
    wr_line = mk_line(32'hD0);
    tick();
    for (int e = 0; e < 4; e++) tick();
    dbg_we    = 1'b1;
    dbg_addr  = 32'h3FE0;
    dbg_wdata = 32'hDEAD;
    tick();
    dbg_we = 1'b0;
    wr_req = 1'b0;
    wait_gnt("last", 5, 12);
    dbg_rd("last_dbg0", 32'h3FE0, 32'hD0);
    dbg_rd("last_dbg7", 32'h3FFC, 32'hD7);
    run_txn("lastrd", 1'b1, 1'b0, 9'h1FF, '0, 12);
    check("lastrd_w0", rd_line[31:0], 32'hD0);
    check("lastrd_w7", rd_line[255:224], 32'hD7);

    np = 0;
    gidx = '{default: 0};
    b_rd_req = 1'b1;
    tick();
    for (int e = 1; e <= 29; e++) begin
      tick();
      if (b_gnt) begin
        if (np < 3) gidx[np] = e;
        np++;
        if (e == 28) b_rd_req = 1'b0;
      end
      if (e == 9 || e == 19)
        check($sformatf("l0_idle%0d", e), {31'd0, b_busy}, 32'd0);
    end
    b_rd_req = 1'b0;
    check("l0_npulse", np, 3);
    check("l0_g0", gidx[0], 8);
    check("l0_g1", gidx[1], 18);
    check("l0_g2", gidx[2], 28);
    check("l0_cnt", b_rd_cnt, 32'd3);
    tick();
    tick();
    check("l0_noretrig", {31'd0, b_busy}, 32'd0);
    check("l0_cnt2", b_rd_cnt, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
